// File: rtl/sccb_config_sequencer.sv
// Walks a {addr16, data8} register table and issues one SCCB write per entry.
// Handles inline millisecond delay entries and stops at an end marker.
module sccb_config_sequencer #(
   parameter int          CLK_FREQ   = 25000000,
   parameter int          ROM_AW     = 8,
   parameter logic [15:0] END_ADDR   = 16'hFFFF,
   parameter logic [15:0] DELAY_ADDR = 16'hFFF0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              init_start,
   output logic [ROM_AW-1:0] rom_addr,
   input  logic [23:0]       rom_data,
   output logic              sccb_start,
   output logic [15:0]       sccb_address,
   output logic [7:0]        sccb_data,
   input  logic              sccb_ready,
   output logic              busy,
   output logic              done,
   output logic [ROM_AW:0]   write_count
);

   localparam int MS_CYCLES = (CLK_FREQ / 1000 > 0) ? CLK_FREQ / 1000 : 1;
   localparam int CW = (MS_CYCLES > 1) ? $clog2(MS_CYCLES) : 1;
   localparam logic [CW-1:0] CYC_RELOAD = CW'(MS_CYCLES - 1);
   localparam logic [ROM_AW-1:0] LAST_ADDR = '1;

   typedef enum logic [3:0] {
      S_IDLE,
      S_FETCH,
      S_LATCH,
      S_DECODE,
      S_ISSUE,
      S_WAIT_ACK,
      S_WAIT_DONE,
      S_DELAY,
      S_NEXT,
      S_FINISH
   } state_t;

   state_t            state_q, state_d;
   logic [ROM_AW-1:0] rom_addr_q, rom_addr_d;
   logic [23:0]       entry_q, entry_d;
   logic              sccb_start_q, sccb_start_d;
   logic [15:0]       sccb_address_q, sccb_address_d;
   logic [7:0]        sccb_data_q, sccb_data_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic [ROM_AW:0]   write_count_q, write_count_d;
   logic [7:0]        ms_count_q, ms_count_d;
   logic [CW-1:0]     cycle_count_q, cycle_count_d;

   logic [15:0] entry_addr;
   logic [7:0]  entry_val;

   assign entry_addr = entry_q[23:8];
   assign entry_val  = entry_q[7:0];

   // Next-state and next-output computation for the table walker.
   always_comb begin
      state_d        = state_q;
      rom_addr_d     = rom_addr_q;
      entry_d        = entry_q;
      sccb_start_d   = 1'b0;
      sccb_address_d = sccb_address_q;
      sccb_data_d    = sccb_data_q;
      busy_d         = busy_q;
      done_d         = done_q;
      write_count_d  = write_count_q;
      ms_count_d     = ms_count_q;
      cycle_count_d  = cycle_count_q;

      unique case (state_q)
         S_IDLE: begin
            if (init_start) begin
               rom_addr_d    = '0;
               write_count_d = '0;
               done_d        = 1'b0;
               busy_d        = 1'b1;
               state_d       = S_FETCH;
            end
         end
         S_FETCH: begin
            state_d = S_LATCH;
         end
         S_LATCH: begin
            entry_d = rom_data;
            state_d = S_DECODE;
         end
         S_DECODE: begin
            if (entry_addr == END_ADDR) begin
               state_d = S_FINISH;
            end else if (entry_addr == DELAY_ADDR) begin
               ms_count_d    = entry_val;
               cycle_count_d = CYC_RELOAD;
               state_d = (entry_val == 8'd0) ? S_NEXT : S_DELAY;
            end else begin
               sccb_address_d = entry_addr;
               sccb_data_d    = entry_val;
               state_d        = S_ISSUE;
            end
         end
         S_ISSUE: begin
            // The engine is never reset, so it may still be busy here.
            if (sccb_ready) begin
               sccb_start_d  = 1'b1;
               write_count_d = write_count_q + 1'b1;
               state_d       = S_WAIT_ACK;
            end
         end
         S_WAIT_ACK: begin
            if (!sccb_ready) begin
               state_d = S_WAIT_DONE;
            end
         end
         S_WAIT_DONE: begin
            if (sccb_ready) begin
               state_d = S_NEXT;
            end
         end
         S_DELAY: begin
            if (cycle_count_q == '0) begin
               if (ms_count_q <= 8'd1) begin
                  ms_count_d = 8'd0;
                  state_d    = S_NEXT;
               end else begin
                  ms_count_d    = ms_count_q - 8'd1;
                  cycle_count_d = CYC_RELOAD;
               end
            end else begin
               cycle_count_d = cycle_count_q - 1'b1;
            end
         end
         S_NEXT: begin
            // No wrap: a table without an end marker stops at the last slot.
            if (rom_addr_q == LAST_ADDR) begin
               state_d = S_FINISH;
            end else begin
               rom_addr_d = rom_addr_q + 1'b1;
               state_d    = S_FETCH;
            end
         end
         S_FINISH: begin
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State and output registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q        <= S_IDLE;
         rom_addr_q     <= '0;
         entry_q        <= '0;
         sccb_start_q   <= 1'b0;
         sccb_address_q <= '0;
         sccb_data_q    <= '0;
         busy_q         <= 1'b0;
         done_q         <= 1'b0;
         write_count_q  <= '0;
         ms_count_q     <= '0;
         cycle_count_q  <= '0;
      end else begin
         state_q        <= state_d;
         rom_addr_q     <= rom_addr_d;
         entry_q        <= entry_d;
         sccb_start_q   <= sccb_start_d;
         sccb_address_q <= sccb_address_d;
         sccb_data_q    <= sccb_data_d;
         busy_q         <= busy_d;
         done_q         <= done_d;
         write_count_q  <= write_count_d;
         ms_count_q     <= ms_count_d;
         cycle_count_q  <= cycle_count_d;
      end
   end

   assign rom_addr     = rom_addr_q;
   assign sccb_start   = sccb_start_q;
   assign sccb_address = sccb_address_q;
   assign sccb_data    = sccb_data_q;
   assign busy         = busy_q;
   assign done         = done_q;
   assign write_count  = write_count_q;

endmodule
